// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control-word bit indices,
// operation select encodings and the default operand width.
package alu_pkg;

   localparam int W_DEFAULT = 8;
   localparam int C_WIDTH   = 15;

   // Bit positions inside the one-hot control word c[14:0]
   localparam int C_LD_ADD   = 0;   // add/sub operand load
   localparam int C_LD_MUL   = 1;   // multiply operand load
   localparam int C_LD_DIV   = 2;   // divide operand load (pre-shifted)
   localparam int C_DECIDE   = 3;   // decision cycle, registers hold
   localparam int C_ADDSUB   = 4;   // A <= A +/- sext(M)
   localparam int C_SUB      = 5;   // qualifies C_ADDSUB as subtract
   localparam int C_QBIT     = 6;   // Q[0] <= ~A[W]
   localparam int C_CNT      = 7;   // cnt <= cnt + 1
   localparam int C_ASR      = 8;   // arithmetic right shift {A,Q,Q[-1]}
   localparam int C_SHL      = 9;   // logical left shift {A,Q}
   localparam int C_CNT_WRAP = 10;  // cnt <= cnt + 1 (wraps)
   localparam int C_CORR     = 11;  // remainder correction A <= A + sext(M)
   localparam int C_OUT_LO   = 12;  // res low half <= A
   localparam int C_OUT_PROD = 13;  // res <= {A, Q}
   localparam int C_OUT_Q    = 14;  // res high half <= Q

   typedef enum logic [1:0] {
      SEL_ADD = 2'b00,
      SEL_SUB = 2'b01,
      SEL_MUL = 2'b10,
      SEL_DIV = 2'b11
   } sel_e;

endpackage

// File: rtl/alu_datapath_addsub.sv
// Shared N-bit two's-complement adder/subtractor; carry-out is dropped.
module alu_addsub
   import alu_pkg::*;
#(
   parameter int N = W_DEFAULT + 1
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum
);

   // Select add or subtract of the two operands
   always_comb begin
      sum = a;
      if (sub) begin
         sum = a - b;
      end else begin
         sum = a + b;
      end
   end

endmodule

// File: rtl/alu_datapath.sv
// Register-transfer datapath of the sequential ALU. Executes add/sub,
// Booth multiply and non-restoring divide under a one-hot control word and
// returns the status bits the control FSM branches on.
module alu_datapath
   import alu_pkg::*;
#(
   parameter int W  = W_DEFAULT,
   parameter int CW = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [14:0]    c,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic           q_0,
   output logic           q_min1,
   output logic           sign,
   output logic           cnt7,
   output logic [2*W-1:0] res
);

   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [W:0]     a_r,   a_nxt_s;
   logic [W-1:0]   q_r,   q_nxt_s;
   logic [W-1:0]   m_r,   m_nxt_s;
   logic           qm1_r, qm1_nxt_s;
   logic [CW-1:0]  cnt_r, cnt_nxt_s;
   logic [2*W-1:0] res_r, res_nxt_s;
   logic [W:0]     sum_s;
   logic           sub_s;
   logic           load_s;

   // The correction step (c[11]) always adds; only c[4] honours c[5]
   always_comb begin
      sub_s = 1'b0;
      if (c[C_ADDSUB]) begin
         sub_s = c[C_SUB];
      end else begin
         sub_s = 1'b0;
      end
   end

   alu_addsub #(.N(W + 1)) u_addsub (
      .a   (a_r),
      .b   ({m_r[W-1], m_r}),
      .sub (sub_s),
      .sum (sum_s)
   );

   assign load_s = c[C_LD_ADD] | c[C_LD_MUL] | c[C_LD_DIV];

   // Next-state of A and Q; lowest control index wins when several are set
   always_comb begin
      a_nxt_s = a_r;
      q_nxt_s = q_r;
      if (c[C_LD_ADD]) begin
         a_nxt_s = {x[W-1], x};
         q_nxt_s = {W{1'b0}};
      end else if (c[C_LD_MUL]) begin
         a_nxt_s = {(W+1){1'b0}};
         q_nxt_s = x;
      end else if (c[C_LD_DIV]) begin
         // {A,Q} <= {0, x} << 1 so the first subtract lines up
         a_nxt_s = {{W{1'b0}}, x[W-1]};
         q_nxt_s = {x[W-2:0], 1'b0};
      end else if (c[C_DECIDE]) begin
         a_nxt_s = a_r;
         q_nxt_s = q_r;
      end else if (c[C_ADDSUB]) begin
         a_nxt_s = sum_s;
      end else if (c[C_QBIT]) begin
         q_nxt_s = {q_r[W-1:1], ~a_r[W]};
      end else if (c[C_ASR]) begin
         a_nxt_s = {a_r[W], a_r[W:1]};
         q_nxt_s = {a_r[0], q_r[W-1:1]};
      end else if (c[C_SHL]) begin
         a_nxt_s = {a_r[W-1:0], q_r[W-1]};
         q_nxt_s = {q_r[W-2:0], 1'b0};
      end else if (c[C_CORR]) begin
         a_nxt_s = sum_s;
      end else begin
         a_nxt_s = a_r;
         q_nxt_s = q_r;
      end
   end

   // Next-state of M, Q[-1] and the iteration counter
   always_comb begin
      m_nxt_s   = m_r;
      qm1_nxt_s = qm1_r;
      cnt_nxt_s = cnt_r;
      if (load_s) begin
         m_nxt_s   = y;
         qm1_nxt_s = 1'b0;
         cnt_nxt_s = {CW{1'b0}};
      end else begin
         if (c[C_CNT] || c[C_CNT_WRAP]) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
         end else begin
            cnt_nxt_s = cnt_r;
         end
         if (c[C_ASR]) begin
            qm1_nxt_s = q_r[0];
         end else begin
            qm1_nxt_s = qm1_r;
         end
      end
   end

   // Next-state of the result register; holds unless an output strobe is set
   always_comb begin
      res_nxt_s = res_r;
      if (c[C_OUT_LO]) begin
         res_nxt_s = {res_r[2*W-1:W], a_r[W-1:0]};
      end else if (c[C_OUT_PROD]) begin
         res_nxt_s = {a_r[W-1:0], q_r};
      end else if (c[C_OUT_Q]) begin
         res_nxt_s = {q_r, res_r[W-1:0]};
      end else begin
         res_nxt_s = res_r;
      end
   end

   // Datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= {(W+1){1'b0}};
         q_r   <= {W{1'b0}};
         m_r   <= {W{1'b0}};
         qm1_r <= 1'b0;
         cnt_r <= {CW{1'b0}};
         res_r <= {(2*W){1'b0}};
      end else begin
         a_r   <= a_nxt_s;
         q_r   <= q_nxt_s;
         m_r   <= m_nxt_s;
         qm1_r <= qm1_nxt_s;
         cnt_r <= cnt_nxt_s;
         res_r <= res_nxt_s;
      end
   end

   assign q_0    = q_r[0];
   assign q_min1 = qm1_r;
   assign sign   = a_r[W];
   assign cnt7   = (cnt_r == CNT_LAST);
   assign res    = res_r;

endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: the stimulus process models the control
// FSM and queues expected results; a monitor process compares them.
module tb_alu_datapath;
    import alu_pkg::*;

    localparam int W = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [14:0]   c     = 15'h0000;
    logic [W-1:0]  x     = 8'h00;
    logic [W-1:0]  y     = 8'h00;
    logic          q_0, q_min1, sign, cnt7;
    logic [2*W-1:0] res;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int iter_obs = 0;

    int          due_q[$];
    int          kind_q[$];
    logic [15:0] val_q[$];
    string       name_q[$];

    alu_datapath #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .c      (c),
        .x      (x),
        .y      (y),
        .q_0    (q_0),
        .q_min1 (q_min1),
        .sign   (sign),
        .cnt7   (cnt7),
        .res    (res)
    );

    always #5 clk = ~clk;

    // cycle counter, advanced on every rising edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [14:0] cb(input int i);
        logic [14:0] one;
        one = 15'h0001;
        return one << i;
    endfunction

    // kinds: 0 res, 2 sign, 6 {q_0,q_min1,sign,cnt7}, 7 observed iteration count
    function automatic logic [15:0] observe(input int kind);
        case (kind)
            0:       return res;
            2:       return {15'h0000, sign};
            6:       return {12'h000, q_0, q_min1, sign, cnt7};
            7:       return 16'(iter_obs);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic expect_at(input int due, input int kind, input logic [15:0] val, input string name);
        due_q.push_back(due);
        kind_q.push_back(kind);
        val_q.push_back(val);
        name_q.push_back(name);
    endtask

    // monitor: compare every expectation that has come due, on the falling edge
    initial forever begin
        @(negedge clk);
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            logic [15:0] act;
            act = observe(kind_q[0]);
            total = total + 1;
            if (act !== val_q[0]) begin
                bad = bad + 1;
                $display("FAIL %s: got 0x%04h want 0x%04h", name_q[0], act, val_q[0]);
            end
            void'(due_q.pop_front());
            void'(kind_q.pop_front());
            void'(val_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    task automatic tick(input logic [14:0] cw);
        @(negedge clk);
        c = cw;
    endtask

    task automatic tick_xy(input logic [14:0] cw, input logic [7:0] xv, input logic [7:0] yv);
        @(negedge clk);
        c = cw;
        x = xv;
        y = yv;
    endtask

    // Booth multiply sequence; rst_iter >= 0 pulls reset during that iteration
    task automatic run_mul(input logic [7:0] xv, input logic [7:0] yv,
                           input logic [15:0] want, input int rst_iter);
        logic [1:0] pair;
        tick_xy(cb(C_LD_MUL), xv, yv);
        iter_obs = 0;
        for (int it = 0; it < 20; it++) begin
            tick(cb(C_DECIDE));
            pair = {q_0, q_min1};
            if (pair == 2'b10) begin
                tick(cb(C_ADDSUB) | cb(C_SUB));
            end else if (pair == 2'b01) begin
                tick(cb(C_ADDSUB));
            end
            tick(cb(C_ASR));
            if (it == rst_iter) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                expect_at(cyc, 0, 16'h0000, "rst_mid_res");
                expect_at(cyc, 6, 16'h0000, "rst_mid_status");
                return;
            end
            tick(cb(C_CNT_WRAP));
            iter_obs = iter_obs + 1;
            if (cnt7) break;
        end
        expect_at(cyc + 1, 7, 16'd8, "mul_iterations");
        tick(cb(C_OUT_PROD));
        expect_at(cyc + 1, 0, want, "mul_res");
        tick(15'h0000);
    endtask

    // non-restoring divide sequence
    task automatic run_div(input logic [7:0] xv, input logic [7:0] yv,
                           input logic [15:0] want, input string name);
        tick_xy(cb(C_LD_DIV), xv, yv);
        iter_obs = 0;
        for (int it = 0; it < 20; it++) begin
            tick(cb(C_DECIDE));
            if (sign) begin
                tick(cb(C_ADDSUB));
            end else begin
                tick(cb(C_ADDSUB) | cb(C_SUB));
            end
            tick(cb(C_QBIT));
            tick(cb(C_CNT));
            iter_obs = iter_obs + 1;
            if (cnt7) break;
            tick(cb(C_SHL));
        end
        expect_at(cyc + 1, 7, 16'd8, {name, "_iterations"});
        tick(cb(C_DECIDE));
        if (sign) begin
            tick(cb(C_CORR));
        end
        tick(cb(C_OUT_LO));
        tick(cb(C_OUT_Q));
        expect_at(cyc + 1, 0, want, name);
        tick(15'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        expect_at(1, 0, 16'h0000, "reset_res");
        expect_at(1, 6, 16'h0000, "reset_status");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // add 100 + 27
        tick_xy(cb(C_LD_ADD), 8'd100, 8'd27);
        tick(cb(C_ADDSUB));
        tick(cb(C_OUT_LO));
        expect_at(cyc + 1, 0, 16'h007F, "add_res");
        expect_at(cyc + 1, 2, 16'h0000, "add_sign");

        // sub 5 - 9
        tick_xy(cb(C_LD_ADD), 8'd5, 8'd9);
        tick(cb(C_ADDSUB) | cb(C_SUB));
        tick(cb(C_OUT_LO));
        expect_at(cyc + 1, 0, 16'h00FC, "sub_res");
        expect_at(cyc + 1, 2, 16'h0001, "sub_sign");

        // c[5] alone leaves A untouched
        tick(cb(C_SUB));
        tick(cb(C_OUT_LO));
        expect_at(cyc + 1, 0, 16'h00FC, "c5_alone_res");
        expect_at(cyc + 1, 2, 16'h0001, "c5_alone_sign");

        // res holds across idle/decision cycles
        tick(cb(C_DECIDE));
        tick(15'h0000);
        expect_at(cyc + 1, 0, 16'h00FC, "res_hold");

        // Booth multiply -3 * 5
        run_mul(8'hFD, 8'h05, 16'hFFF1, -1);

        // divide 100 / 7 and divide by zero
        run_div(8'd100, 8'd7, 16'h0E02, "div_res");
        run_div(8'h5A, 8'h00, 16'hFF5A, "div0_res");

        // reset in the 4th multiply iteration, then a fresh add
        run_mul(8'hFD, 8'h05, 16'hFFF1, 3);
        tick(15'h0000);
        tick(15'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick_xy(cb(C_LD_ADD), 8'd1, 8'd1);
        tick(cb(C_ADDSUB));
        tick(cb(C_OUT_LO));
        expect_at(cyc + 1, 0, 16'h0002, "post_reset_add_res");
        expect_at(cyc + 1, 2, 16'h0000, "post_reset_add_sign");

        tick(15'h0000);
        tick(15'h0000);
        tick(15'h0000);
        @(negedge clk);

        // final direct checks
        total = total + 1;
        if (res !== 16'h0002) begin
            bad = bad + 1;
            $display("FAIL final_res: got 0x%04h want 0x0002", res);
        end
        total = total + 1;
        if (sign !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL final_sign: got %0b want 0", sign);
        end
        total = total + 1;
        if (due_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL pending_expectations: got %0d want 0", due_q.size());
        end
        if (total < 12) begin
            bad = bad + 1;
            $display("FAIL check_count: got %0d want >= 12", total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
